// File: rtl/key_schedule_ctrl_if.sv
// Control/strobe bundle between the AES-128 key-schedule controller and the
// byte-serial key-expansion datapath / downstream cipher.
interface key_schedule_ctrl_if;
  logic       start;
  logic       abort;
  logic       key_req;
  logic [3:0] key_byte_idx;
  logic       input_muxctrl;
  logic       sbox_muxctrl;
  logic       bit_out_muxctrl;
  logic       last_out_muxctrl;
  logic [3:0] round_count;
  logic [7:0] rcon_en;
  logic       rk_valid;
  logic [3:0] rk_round;
  logic [3:0] rk_byte;
  logic       busy;
  logic       done;

  // Controller side
  modport master (
    input  start, abort,
    output key_req, key_byte_idx, input_muxctrl, sbox_muxctrl, bit_out_muxctrl,
           last_out_muxctrl, round_count, rcon_en, rk_valid, rk_round, rk_byte,
           busy, done
  );

  // Requester / datapath side
  modport slave (
    output start, abort,
    input  key_req, key_byte_idx, input_muxctrl, sbox_muxctrl, bit_out_muxctrl,
           last_out_muxctrl, round_count, rcon_en, rk_valid, rk_round, rk_byte,
           busy, done
  );
endinterface

// File: rtl/key_schedule_ctrl.sv
// Control FSM for the byte-serial AES-128 key expansion: 16-cycle key load,
// NUM_ROUNDS x 16-cycle expansion, plus KEY_LAT-delayed round-key byte tags.
module key_schedule_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_LAT    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  key_schedule_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_EXPAND = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  typedef struct packed {
    logic       active;
    logic [3:0] round;
    logic [3:0] idx;
  } tag_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_byte_cnt;
  logic [3:0] w_byte_cnt_nxt;
  logic [3:0] r_round_cnt;
  logic [3:0] w_round_cnt_nxt;
  tag_t       w_tag;
  tag_t       r_tag_pipe [KEY_LAT];

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_byte_cnt  <= 4'd0;
      r_round_cnt <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_round_cnt <= w_round_cnt_nxt;
    end
  end

  // Next-state and counter sequencing; abort overrides everything
  always_comb begin
    w_state_nxt     = r_state;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_round_cnt_nxt = r_round_cnt;
    if (bus.abort) begin
      w_state_nxt     = S_IDLE;
      w_byte_cnt_nxt  = 4'd0;
      w_round_cnt_nxt = 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_state_nxt    = S_LOAD;
            w_byte_cnt_nxt = 4'd0;
          end else begin
            w_state_nxt    = S_IDLE;
          end
        end
        S_LOAD: begin
          w_byte_cnt_nxt = r_byte_cnt + 4'd1;
          if (r_byte_cnt == 4'd15) begin
            w_state_nxt     = S_EXPAND;
            w_round_cnt_nxt = 4'd0;
          end else begin
            w_state_nxt     = S_LOAD;
          end
        end
        S_EXPAND: begin
          w_byte_cnt_nxt = r_byte_cnt + 4'd1;
          if (r_byte_cnt == 4'd15) begin
            if (r_round_cnt == LAST_ROUND) begin
              w_state_nxt     = S_FIN;
              w_round_cnt_nxt = 4'd0;
            end else begin
              w_round_cnt_nxt = r_round_cnt + 4'd1;
            end
          end else begin
            w_round_cnt_nxt = r_round_cnt;
          end
        end
        S_FIN: begin
          w_state_nxt     = S_IDLE;
          w_byte_cnt_nxt  = 4'd0;
          w_round_cnt_nxt = 4'd0;
        end
        default: begin
          w_state_nxt     = S_IDLE;
          w_byte_cnt_nxt  = 4'd0;
          w_round_cnt_nxt = 4'd0;
        end
      endcase
    end
  end

  // Moore decode of datapath controls, status and the round-key tag
  always_comb begin
    bus.key_req          = 1'b0;
    bus.key_byte_idx     = 4'd0;
    bus.input_muxctrl    = 1'b0;
    bus.sbox_muxctrl     = 1'b0;
    bus.bit_out_muxctrl  = 1'b1;
    bus.last_out_muxctrl = 1'b0;
    bus.round_count      = 4'd0;
    bus.rcon_en          = 8'h00;
    bus.busy             = 1'b0;
    bus.done             = 1'b0;
    w_tag                = '0;
    case (r_state)
      S_LOAD: begin
        bus.key_req       = 1'b1;
        bus.key_byte_idx  = r_byte_cnt;
        bus.input_muxctrl = 1'b1;
        bus.busy          = 1'b1;
        w_tag             = '{active: 1'b1, round: 4'd0, idx: r_byte_cnt};
      end
      S_EXPAND: begin
        bus.busy             = 1'b1;
        bus.round_count      = r_round_cnt;
        bus.rcon_en          = (r_byte_cnt == 4'd0) ? 8'hFF : 8'h00;
        bus.sbox_muxctrl     = (r_byte_cnt == 4'd3);
        bus.last_out_muxctrl = (r_byte_cnt < 4'd4);
        bus.bit_out_muxctrl  = (r_byte_cnt >= 4'd12);
        // Round key 0 is the loaded key, so expansion round r yields key r+1
        w_tag = '{active: 1'b1, round: r_round_cnt + 4'd1, idx: r_byte_cnt};
      end
      S_FIN: begin
        bus.done = 1'b1;
      end
      default: begin
        bus.done = 1'b0;
      end
    endcase
  end

  // Tag delay line aligned with the datapath key_out tap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KEY_LAT; i++) r_tag_pipe[i] <= '0;
    end else if (bus.abort) begin
      for (int i = 0; i < KEY_LAT; i++) r_tag_pipe[i] <= '0;
    end else begin
      r_tag_pipe[0] <= w_tag;
      for (int i = 1; i < KEY_LAT; i++) r_tag_pipe[i] <= r_tag_pipe[i-1];
    end
  end

  assign bus.rk_valid = r_tag_pipe[KEY_LAT-1].active;
  assign bus.rk_round = r_tag_pipe[KEY_LAT-1].round;
  assign bus.rk_byte  = r_tag_pipe[KEY_LAT-1].idx;

endmodule
